// File: rtl/gba_cart_rom_responder_if.sv
// GBA slot-2 ROM bus plus backing-memory request channel.
// slave  : cartridge responder side
// master : console / memory model side
`timescale 1ns/1ps
interface gba_cart_rom_responder_if #(
   parameter int ADDR_W = 24
);
   logic              bus_ncs;
   logic              bus_nrd;
   logic              bus_nwr;
   logic [15:0]       bus_ad_in;
   logic [7:0]        bus_a_hi;
   logic [15:0]       bus_ad_out;
   logic              bus_ad_oe;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [15:0]       mem_rdata;

   modport slave (
      input  bus_ncs, bus_nrd, bus_nwr, bus_ad_in, bus_a_hi, mem_ack, mem_rdata,
      output bus_ad_out, bus_ad_oe, mem_req, mem_addr
   );

   modport master (
      output bus_ncs, bus_nrd, bus_nwr, bus_ad_in, bus_a_hi, mem_ack, mem_rdata,
      input  bus_ad_out, bus_ad_oe, mem_req, mem_addr
   );
endinterface

// File: rtl/gba_cart_rom_responder.sv
// Cartridge-side responder for the GBA slot-2 ROM bus. Oversamples the async
// strobes, latches the address on nCS fall, auto-increments it per nRD pulse
// (lower 16 bits only), and keeps one halfword prefetched from backing memory.
// Optional build macro GBA_RESP_STATS_EN adds read / underrun statistics ports.
//
// state  | meaning
// IDLE   | nCS high; a stale request may still be waiting for its ack
// FETCH  | buffer empty, request for addr outstanding or about to issue
// READY  | buffer holds data for addr, waiting for nRD fall
// DRIVE  | nRD low, AD driven from buffer
// HOLD   | nRD has risen, AD kept driven for HOLD_CYC cycles
// PEND   | nRD fell with buffer empty (underrun), drive once data arrives
`timescale 1ns/1ps
module gba_cart_rom_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYC    = 2,
   parameter int ADDR_W      = 24
) (
   input  logic                      clk,
   input  logic                      rst_n,
   gba_cart_rom_responder_if.slave   bus,
   output logic                      underrun
`ifdef GBA_RESP_STATS_EN
   ,
   output logic [15:0]               stat_rd_cnt,
   output logic [7:0]                stat_unr_cnt
`endif
);

   typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_READY, ST_DRIVE, ST_HOLD, ST_PEND} state_t;
   localparam int HW = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;

   logic [SYNC_STAGES-1:0] ncs_sh, nrd_sh, nwr_sh;
   logic [15:0]            ad_dly  [SYNC_STAGES];
   logic [7:0]             ahi_dly [SYNC_STAGES];
   logic                   ncs_p, nrd_p;
   logic                   ncs_s, nrd_s, nwr_s;
   logic                   ncs_fall, ncs_rise, nrd_fall, nrd_rise;

   state_t            state_q, state_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt, mem_addr_q, mem_addr_nxt;
   logic [15:0]       data_buf_q, data_buf_nxt, ad_out_q, ad_out_nxt;
   logic              mem_req_q, mem_req_nxt, stale_q, stale_nxt;
   logic              oe_q, oe_nxt, unr_q, unr_nxt, ack_ok;
   logic [HW-1:0]     hold_q, hold_nxt;

   // Synchronise strobes; delay AD/A_HI equally so they line up with synced nCS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ncs_sh <= '1;
         nrd_sh <= '1;
         nwr_sh <= '1;
         ncs_p  <= 1'b1;
         nrd_p  <= 1'b1;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            ad_dly[i]  <= '0;
            ahi_dly[i] <= '0;
         end
      end else begin
         ncs_sh     <= (ncs_sh << 1) | SYNC_STAGES'(bus.bus_ncs);
         nrd_sh     <= (nrd_sh << 1) | SYNC_STAGES'(bus.bus_nrd);
         nwr_sh     <= (nwr_sh << 1) | SYNC_STAGES'(bus.bus_nwr);
         ncs_p      <= ncs_s;
         nrd_p      <= nrd_s;
         ad_dly[0]  <= bus.bus_ad_in;
         ahi_dly[0] <= bus.bus_a_hi;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            ad_dly[i]  <= ad_dly[i-1];
            ahi_dly[i] <= ahi_dly[i-1];
         end
      end
   end

   assign ncs_s    = ncs_sh[SYNC_STAGES-1];
   assign nrd_s    = nrd_sh[SYNC_STAGES-1];
   assign nwr_s    = nwr_sh[SYNC_STAGES-1];
   assign ncs_fall = ncs_p & ~ncs_s;
   assign ncs_rise = ~ncs_p & ncs_s;
   assign nrd_fall = nrd_p & ~nrd_s;
   assign nrd_rise = ~nrd_p & nrd_s;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         mem_addr_q <= '0;
         data_buf_q <= '0;
         ad_out_q   <= '0;
         mem_req_q  <= 1'b0;
         stale_q    <= 1'b0;
         oe_q       <= 1'b0;
         unr_q      <= 1'b0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_nxt;
         addr_q     <= addr_nxt;
         mem_addr_q <= mem_addr_nxt;
         data_buf_q <= data_buf_nxt;
         ad_out_q   <= ad_out_nxt;
         mem_req_q  <= mem_req_nxt;
         stale_q    <= stale_nxt;
         oe_q       <= oe_nxt;
         unr_q      <= unr_nxt;
         hold_q     <= hold_nxt;
      end
   end

   // Next-state logic; an ack for a request issued before nCS rose is swallowed.
   always_comb begin
      state_nxt    = state_q;
      addr_nxt     = addr_q;
      mem_addr_nxt = mem_addr_q;
      data_buf_nxt = data_buf_q;
      ad_out_nxt   = ad_out_q;
      mem_req_nxt  = mem_req_q;
      stale_nxt    = stale_q;
      oe_nxt       = oe_q;
      unr_nxt      = unr_q;
      hold_nxt     = hold_q;
      ack_ok       = bus.mem_ack & mem_req_q & ~stale_q;

      if (bus.mem_ack && mem_req_q) begin
         mem_req_nxt = 1'b0;
         stale_nxt   = 1'b0;
      end

      if (ncs_rise) begin
         state_nxt = ST_IDLE;
         oe_nxt    = 1'b0;
         if (mem_req_q && !bus.mem_ack) stale_nxt = 1'b1;
         if (nrd_rise) addr_nxt[15:0] = addr_q[15:0] + 16'd1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ncs_fall) begin
                  addr_nxt  = ADDR_W'({ahi_dly[SYNC_STAGES-1], ad_dly[SYNC_STAGES-1]});
                  unr_nxt   = 1'b0;
                  state_nxt = ST_FETCH;
                  if (!mem_req_q) begin
                     mem_req_nxt  = 1'b1;
                     mem_addr_nxt = ADDR_W'({ahi_dly[SYNC_STAGES-1], ad_dly[SYNC_STAGES-1]});
                  end
               end
            end
            ST_FETCH: begin
               if (ack_ok) begin
                  data_buf_nxt = bus.mem_rdata;
                  if (nrd_fall) begin
                     state_nxt  = ST_DRIVE;
                     oe_nxt     = 1'b1;
                     ad_out_nxt = bus.mem_rdata;
                  end else begin
                     state_nxt = ST_READY;
                  end
               end else begin
                  if (!mem_req_q) begin
                     mem_req_nxt  = 1'b1;
                     mem_addr_nxt = addr_q;
                  end
                  if (nrd_fall) begin
                     unr_nxt   = 1'b1;
                     state_nxt = ST_PEND;
                  end
               end
            end
            ST_READY: begin
               if (nrd_fall) begin
                  state_nxt  = ST_DRIVE;
                  oe_nxt     = 1'b1;
                  ad_out_nxt = data_buf_q;
               end
            end
            ST_DRIVE: begin
               if (nrd_rise) begin
                  addr_nxt[15:0] = addr_q[15:0] + 16'd1;
                  if (HOLD_CYC == 0) begin
                     state_nxt = ST_FETCH;
                     oe_nxt    = 1'b0;
                  end else begin
                     state_nxt = ST_HOLD;
                     hold_nxt  = HW'(HOLD_CYC - 1);
                  end
               end
            end
            ST_HOLD: begin
               if (nrd_fall) begin
                  unr_nxt   = 1'b1;
                  oe_nxt    = 1'b0;
                  state_nxt = ST_PEND;
               end else if (hold_q == '0) begin
                  state_nxt = ST_FETCH;
                  oe_nxt    = 1'b0;
               end else begin
                  hold_nxt = hold_q - HW'(1);
               end
            end
            ST_PEND: begin
               if (nrd_rise) begin
                  addr_nxt[15:0] = addr_q[15:0] + 16'd1;
                  state_nxt      = ST_FETCH;
                  if (mem_req_q && !bus.mem_ack) stale_nxt = 1'b1;
               end else if (ack_ok) begin
                  data_buf_nxt = bus.mem_rdata;
                  ad_out_nxt   = bus.mem_rdata;
                  oe_nxt       = 1'b1;
                  state_nxt    = ST_DRIVE;
               end else if (!mem_req_q) begin
                  mem_req_nxt  = 1'b1;
                  mem_addr_nxt = addr_q;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // A console write cycle must never see the cartridge driving AD.
   assign bus.bus_ad_oe  = oe_q & nwr_s;
   assign bus.bus_ad_out = ad_out_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_addr   = mem_addr_q;
   assign underrun       = unr_q;

`ifdef GBA_RESP_STATS_EN
   // Read pulses under nCS (wrapping) and underrun events (saturating).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_rd_cnt  <= '0;
         stat_unr_cnt <= '0;
      end else begin
         if (nrd_rise && !ncs_s) stat_rd_cnt <= stat_rd_cnt + 16'd1;
         if (state_nxt == ST_PEND && state_q != ST_PEND && stat_unr_cnt != 8'hFF)
            stat_unr_cnt <= stat_unr_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gba_cart_rom_responder.sv
// Randomised bench for gba_cart_rom_responder: a console-side bus driver, a
// backing-memory responder with programmable latency, and a transaction-level
// expectation of burst data / fetched addresses.
`timescale 1ns/1ps
module tb_gba_cart_rom_responder;
   localparam int S = 2;
   localparam int H = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic underrun;
   always #5 clk = ~clk;

   gba_cart_rom_responder_if #(.ADDR_W(24)) bif ();
`ifdef GBA_RESP_STATS_EN
   logic [15:0] stat_rd_cnt;
   logic [7:0]  stat_unr_cnt;
`endif

   gba_cart_rom_responder #(.SYNC_STAGES(S), .HOLD_CYC(H), .ADDR_W(24)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bif),
      .underrun (underrun)
`ifdef GBA_RESP_STATS_EN
      ,
      .stat_rd_cnt  (stat_rd_cnt),
      .stat_unr_cnt (stat_unr_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // backing memory: word = low address half xor a per-test salt
   int          mem_lat  = 2;
   logic [15:0] mem_salt = '0;
   logic [23:0] req_q[$];
   longint      ack_t    = 0;
   int          rst_epoch = 0;

   function automatic logic [15:0] mem_word(input logic [23:0] a);
      return a[15:0] ^ mem_salt;
   endfunction

   function automatic logic [23:0] seq_addr(input logic [23:0] a, input int k);
      logic [15:0] lo;
      lo = a[15:0] + 16'(k);
      return {a[23:16], lo};
   endfunction

   initial begin
      logic [23:0] a;
      int lat, ep;
      bif.mem_ack   = 1'b0;
      bif.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (bif.mem_req === 1'b1) begin
            a   = bif.mem_addr;
            lat = mem_lat;
            ep  = rst_epoch;
            req_q.push_back(a);
            repeat (lat) @(negedge clk);
            if (ep == rst_epoch)
               check_val("mem_req_stable", {7'b0, bif.mem_req, bif.mem_addr}, {7'b0, 1'b1, a});
            bif.mem_rdata = mem_word(a);
            bif.mem_ack   = 1'b1;
            ack_t         = $time;
            @(negedge clk);
            bif.mem_ack   = 1'b0;
         end
      end
   end

   initial begin
      #300us;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_idle();
      bif.bus_ncs   = 1'b1;
      bif.bus_nrd   = 1'b1;
      bif.bus_nwr   = 1'b1;
   endtask

   task automatic start_burst(input logic [23:0] a, output int req_lat);
      bif.bus_a_hi  = a[23:16];
      bif.bus_ad_in = a[15:0];
      bif.bus_ncs   = 1'b0;
      req_lat = -1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (req_lat < 0 && bif.mem_req === 1'b1) req_lat = k;
      end
      bif.bus_ad_in = 16'($urandom);
   endtask

   task automatic rd_pulse(input int low_cyc, output bit seen, output int lat,
                           output logic [15:0] data, output int tail);
      bif.bus_nrd = 1'b0;
      seen = 1'b0; lat = -1; data = '0; tail = 0;
      for (int k = 1; k <= low_cyc; k++) begin
         @(negedge clk);
         if (!seen && bif.bus_ad_oe === 1'b1) begin
            seen = 1'b1; lat = k; data = bif.bus_ad_out;
         end
      end
      bif.bus_nrd = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bif.bus_ad_oe === 1'b1 && tail == k - 1) tail = k;
      end
   endtask

   logic [15:0] last_data;

   task automatic run_burst(input logic [23:0] a, input int n, input int low_fix, input string tag);
      int rl, lat, tail, low;
      bit seen;
      logic [15:0] d;
      req_q.delete();
      start_burst(a, rl);
      check_val({tag, "_req_lat"}, rl, S + 1);
      cyc(10);
      for (int i = 0; i < n; i++) begin
         low = (low_fix > 0) ? low_fix : 6 + $urandom_range(0, 4);
         rd_pulse(low, seen, lat, d, tail);
         last_data = d;
         check_val({tag, "_oe_seen"}, 32'(seen), 1);
         check_val({tag, "_oe_lat"}, lat, S + 1);
         check_val({tag, "_ad"}, d, mem_word(seq_addr(a, i)));
         check_val({tag, "_oe_tail"}, tail, S + H);
         cyc($urandom_range(6, 10));
      end
      check_val({tag, "_no_underrun"}, 32'(underrun), 0);
      bif.bus_ncs = 1'b1;
      cyc(10);
      check_val({tag, "_req_cnt"}, req_q.size(), n + 1);
      for (int i = 0; i < n + 1 && i < req_q.size(); i++)
         check_val({tag, "_req_addr"}, req_q[i], seq_addr(a, i));
   endtask

   initial begin
      int rl, lat, tail, cnt;
      bit seen;
      logic [15:0] d;
      logic [23:0] a;
`ifdef GBA_RESP_STATS_EN
      logic [15:0] rd_snap;
`endif
      bus_idle();
      bif.bus_ad_in = '0;
      bif.bus_a_hi  = '0;
      cyc(3);
      check_val("rst_oe",       32'(bif.bus_ad_oe), 0);
      check_val("rst_ad_out",   bif.bus_ad_out, 0);
      check_val("rst_mem_req",  32'(bif.mem_req), 0);
      check_val("rst_mem_addr", bif.mem_addr, 0);
      check_val("rst_underrun", 32'(underrun), 0);
      rst_n = 1'b1;
      cyc(5);

      // non-sequential single read
      mem_salt = 16'hADD8 ^ 16'hDA7A;
      mem_lat  = 2;
      run_burst(24'h00ADD8, 1, 6, "t2");
      check_val("t2_ad_literal", last_data, 16'hDA7A);
`ifdef GBA_RESP_STATS_EN
      check_val("t2_stat_rd", stat_rd_cnt, 1);
`endif

      // sequential wrap with no carry into A_HI
      mem_salt = '0;
      run_burst(24'h12FFFE, 4, 0, "t3");
      cyc(5);

      // underrun: slow memory, nRD falls first
      mem_lat = 20;
      start_burst(24'h3456A0, rl);
      bif.bus_nrd = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!seen && bif.bus_ad_oe === 1'b1) begin
            seen = 1'b1;
            d    = bif.bus_ad_out;
            check_val("t4_oe_after_ack", 32'($time - ack_t), 10);
            mem_lat = 2;
         end
      end
      check_val("t4_oe_seen", 32'(seen), 1);
      check_val("t4_ad", d, mem_word(24'h3456A0));
      check_val("t4_underrun", 32'(underrun), 1);
`ifdef GBA_RESP_STATS_EN
      check_val("t4_stat_unr", stat_unr_cnt, 1);
`endif
      mem_lat = 2;
      bif.bus_nrd = 1'b1;
      cyc(14);
      bif.bus_ncs = 1'b1;
      cyc(6);
      check_val("t4_underrun_sticky", 32'(underrun), 1);
      start_burst(24'h000040, rl);
      check_val("t4_underrun_cleared", 32'(underrun), 0);
      cyc(8);
      bif.bus_ncs = 1'b1;
      cyc(8);

      // asynchronous reset while driving after an underrun
      mem_lat = 20;
      start_burst(24'h0A0010, rl);
      bif.bus_nrd = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (bif.bus_ad_oe === 1'b1) seen = 1'b1;
      end
      check_val("t1_drive_reached", 32'(seen), 1);
      check_val("t1_pre_underrun", 32'(underrun), 1);
      #2;
      rst_epoch++;
      rst_n = 1'b0;
      #1;
      check_val("t1_async_oe",       32'(bif.bus_ad_oe), 0);
      check_val("t1_async_mem_req",  32'(bif.mem_req), 0);
      check_val("t1_async_underrun", 32'(underrun), 0);
      bus_idle();
      mem_lat = 2;
      @(negedge clk);
      cyc(2);
      rst_n = 1'b1;
      cyc(6);

      // abort with request pending, then re-select while the stale ack is due
      req_q.delete();
      mem_lat = 20;
      start_burst(24'h7B2200, rl);
      mem_lat = 2;
      bif.bus_ncs = 1'b1;
      cyc(6);
      check_val("t5_req_held", 32'(bif.mem_req), 1);
      check_val("t5_oe_low",   32'(bif.bus_ad_oe), 0);
      start_burst(24'h000100, rl);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bif.bus_ad_oe === 1'b1) cnt++;
      end
      check_val("t5_oe_stays_low", cnt, 0);
      rd_pulse(8, seen, lat, d, tail);
      check_val("t5_oe_seen", 32'(seen), 1);
      check_val("t5_ad", d, mem_word(24'h000100));
      cyc(8);
      bif.bus_ncs = 1'b1;
      cyc(8);
      check_val("t5_req_cnt", req_q.size(), 3);
      if (req_q.size() == 3) begin
         check_val("t5_req0", req_q[0], 24'h7B2200);
         check_val("t5_req1", req_q[1], 24'h000100);
         check_val("t5_req2", req_q[2], 24'h000101);
      end

      // nWR low keeps AD released
      start_burst(24'h5500F0, rl);
      cyc(10);
`ifdef GBA_RESP_STATS_EN
      rd_snap = stat_rd_cnt;
`endif
      bif.bus_nwr = 1'b0;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bif.bus_ad_oe === 1'b1) cnt++;
      end
`ifdef GBA_RESP_STATS_EN
      check_val("t6_stat_rd_unchanged", stat_rd_cnt, rd_snap);
`endif
      bif.bus_nrd = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bif.bus_ad_oe === 1'b1) cnt++;
      end
      bif.bus_nrd = 1'b1;
      cyc(10);
      check_val("t6_oe_forced_low", cnt, 0);
      bif.bus_nwr = 1'b1;
      bif.bus_ncs = 1'b1;
      cyc(10);

      // randomised bursts
      for (int b = 0; b < 6; b++) begin
         a = 24'($urandom);
         if ($urandom_range(0, 1) == 0) a[15:0] = 16'hFFFF - 16'($urandom_range(0, 3));
         mem_lat  = $urandom_range(1, 4);
         mem_salt = 16'($urandom);
         run_burst(a, $urandom_range(1, 5), 0, "rnd");
         cyc($urandom_range(3, 8));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
